// File: rtl/wave_issue_arbiter_pkg.sv
// Shared types and default sizing for the multi-wavefront issue arbiter.
package wave_issue_arbiter_pkg;

    localparam int NUM_WAVES_DEF    = 4;
    localparam int IB_DEPTH_DEF     = 4;
    localparam int INST_WIDTH_DEF   = 64;
    localparam int MAX_INFLIGHT_DEF = 2;
    localparam int WAVE_ID_W_DEF    = $clog2(NUM_WAVES_DEF);

    typedef logic [WAVE_ID_W_DEF-1:0]  wave_id_t;
    typedef logic [INST_WIDTH_DEF-1:0] inst_word_t;

endpackage

// File: rtl/wave_issue_arbiter_if.sv
// Fetch, issue, completion, flush and status signals of the wave issue arbiter.
interface wave_issue_arbiter_if
    import wave_issue_arbiter_pkg::*;
#(
    parameter int NUM_WAVES  = NUM_WAVES_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF
) ();
    localparam int WAVE_ID_W = $clog2(NUM_WAVES);

    logic                  ifetch_valid;
    logic                  ifetch_ready;
    logic [WAVE_ID_W-1:0]  ifetch_wave;
    logic [INST_WIDTH-1:0] ifetch_inst;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [WAVE_ID_W-1:0]  issue_wave;
    logic [INST_WIDTH-1:0] issue_inst;
    logic                  done_valid;
    logic [WAVE_ID_W-1:0]  done_wave;
    logic [NUM_WAVES-1:0]  wave_enable;
    logic                  flush_valid;
    logic [WAVE_ID_W-1:0]  flush_wave;
    logic [NUM_WAVES-1:0]  ib_full;

    modport master (
        output ifetch_valid, ifetch_wave, ifetch_inst, issue_ready,
               done_valid, done_wave, wave_enable, flush_valid, flush_wave,
        input  ifetch_ready, issue_valid, issue_wave, issue_inst, ib_full
    );

    modport slave (
        input  ifetch_valid, ifetch_wave, ifetch_inst, issue_ready,
               done_valid, done_wave, wave_enable, flush_valid, flush_wave,
        output ifetch_ready, issue_valid, issue_wave, issue_inst, ib_full
    );

endinterface

// File: rtl/wave_issue_arbiter_ib.sv
// Per-wave instruction FIFO; the caller guarantees no push when full and no pop when empty.
module wave_inst_buffer
    import wave_issue_arbiter_pkg::*;
#(
    parameter int IB_DEPTH   = IB_DEPTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [INST_WIDTH-1:0] i_data,
    output logic [INST_WIDTH-1:0] o_head,
    output logic                  o_empty,
    output logic                  o_full
);
    localparam int PTR_W = $clog2(IB_DEPTH);
    localparam int CNT_W = $clog2(IB_DEPTH + 1);

    logic [INST_WIDTH-1:0] r_mem [IB_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(IB_DEPTH));

endmodule

// File: rtl/wave_issue_arbiter.sv
// Buffers fetched instructions per wavefront and issues one eligible wave per cycle,
// round-robin, with a lock that holds the presented instruction until accepted.
module wave_issue_arbiter
    import wave_issue_arbiter_pkg::*;
#(
    parameter int NUM_WAVES    = NUM_WAVES_DEF,
    parameter int IB_DEPTH     = IB_DEPTH_DEF,
    parameter int INST_WIDTH   = INST_WIDTH_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    localparam int WAVE_ID_W   = $clog2(NUM_WAVES)
) (
    input logic                   clk,
    input logic                   rst_n,
    wave_issue_arbiter_if.slave   bus
);
    localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);

    logic [INST_WIDTH-1:0] w_head [NUM_WAVES];
    logic [NUM_WAVES-1:0]  w_empty;
    logic [NUM_WAVES-1:0]  w_full;
    logic [NUM_WAVES-1:0]  w_push;
    logic [NUM_WAVES-1:0]  w_pop;
    logic [NUM_WAVES-1:0]  w_flush;
    logic [NUM_WAVES-1:0]  w_elig;
    logic [NUM_WAVES-1:0]  w_infl_nz;

    logic                  r_lock;
    logic [WAVE_ID_W-1:0]  r_locked_wave;
    logic [WAVE_ID_W-1:0]  r_rr_ptr;

    logic [WAVE_ID_W-1:0]  w_search;
    logic [WAVE_ID_W-1:0]  w_idx;
    logic                  w_any;
    logic [WAVE_ID_W-1:0]  w_winner;
    logic                  w_flush_hit;
    logic                  w_issue_valid;
    logic                  w_hs;
    logic                  w_ifetch_ready;

    assign w_ifetch_ready = !w_full[bus.ifetch_wave] &&
                            !(bus.flush_valid && bus.flush_wave == bus.ifetch_wave);

    for (genvar g = 0; g < NUM_WAVES; g++) begin : g_wave
        logic [INFL_W-1:0] r_inflight;
        logic              w_inc;
        logic              w_dec;

        assign w_push[g]  = bus.ifetch_valid && w_ifetch_ready &&
                            bus.ifetch_wave == WAVE_ID_W'(g);
        assign w_pop[g]   = w_hs && w_winner == WAVE_ID_W'(g);
        assign w_flush[g] = bus.flush_valid && bus.flush_wave == WAVE_ID_W'(g);
        assign w_elig[g]  = bus.wave_enable[g] && !w_empty[g] &&
                            (r_inflight < INFL_W'(MAX_INFLIGHT));

        assign w_infl_nz[g] = (r_inflight != '0);
        assign w_inc = w_pop[g];
        assign w_dec = bus.done_valid && bus.done_wave == WAVE_ID_W'(g) && w_infl_nz[g];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_inflight <= '0;
            end else if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end

        wave_inst_buffer #(
            .IB_DEPTH   (IB_DEPTH),
            .INST_WIDTH (INST_WIDTH)
        ) u_ib (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_flush (w_flush[g]),
            .i_data  (bus.ifetch_inst),
            .o_head  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
    end

    // Scan from the farthest offset down so the nearest eligible wave after rr_ptr wins.
    always_comb begin
        w_search = r_rr_ptr;
        w_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_WAVES; i++) begin
            w_idx = r_rr_ptr + WAVE_ID_W'(NUM_WAVES - 1 - i);
            if (w_elig[w_idx]) begin
                w_search = w_idx;
                w_any    = 1'b1;
            end
        end
    end

    assign w_winner      = r_lock ? r_locked_wave : w_search;
    assign w_flush_hit   = bus.flush_valid && bus.flush_wave == w_winner;
    assign w_issue_valid = (r_lock || w_any) && !w_flush_hit;
    assign w_hs          = w_issue_valid && bus.issue_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_lock        <= 1'b0;
            r_locked_wave <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= w_winner + 1'b1;
            r_lock   <= 1'b0;
        end else if (w_flush_hit) begin
            r_lock <= 1'b0;
        end else if (w_issue_valid) begin
            r_lock        <= 1'b1;
            r_locked_wave <= w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && bus.done_valid) begin
            assert (w_infl_nz[bus.done_wave])
                else $warning("completion on wave %0d with nothing in flight", bus.done_wave);
        end
    end

    assign bus.ifetch_ready = w_ifetch_ready;
    assign bus.issue_valid  = w_issue_valid;
    assign bus.issue_wave   = w_winner;
    assign bus.issue_inst   = w_head[w_winner];
    assign bus.ib_full      = w_full;

endmodule

// File: tb/tb_wave_issue_arbiter.sv
// Directed bench for wave_issue_arbiter with a queue-based reference model checked every cycle.
module tb_wave_issue_arbiter;
    import wave_issue_arbiter_pkg::*;

    localparam int NW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXI  = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wave_issue_arbiter_if #(.NUM_WAVES(NW), .INST_WIDTH(64)) bus ();

    wave_issue_arbiter #(
        .NUM_WAVES    (NW),
        .IB_DEPTH     (DEPTH),
        .INST_WIDTH   (64),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: per-wave instruction queues, inflight counts, round-robin pointer, lock.
    inst_word_t mq [NW][$];
    int         infl [NW];
    int         rr;
    bit         lk;
    int         lkw;
    bit         model_ok;
    int         hs_log [$];

    function automatic inst_word_t mk(input int w, input int k);
        return 64'hC0DE_0000_0000_0000 | (64'(w) << 8) | 64'(k);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : model_proc
        int         win, wi, ifw, fw, dw, dold;
        bit         vraw, fhit, ev, er;
        logic [3:0] ef;
        model_ok = 0;
        forever begin
            @(negedge clk);
            ifw  = int'(bus.ifetch_wave);
            fw   = int'(bus.flush_wave);
            dw   = int'(bus.done_wave);
            vraw = 0;
            win  = 0;
            if (lk) begin
                vraw = 1;
                win  = lkw;
            end else begin
                for (int k = 0; k < NW; k++) begin
                    wi = (rr + k) % NW;
                    if (!vraw && bus.wave_enable[2'(wi)] && mq[wi].size() > 0 && infl[wi] < MAXI) begin
                        vraw = 1;
                        win  = wi;
                    end
                end
            end
            fhit = vraw && bus.flush_valid && fw == win;
            ev   = vraw && !fhit;
            er   = mq[ifw].size() < DEPTH && !(bus.flush_valid && fw == ifw);
            for (int k = 0; k < NW; k++) ef[2'(k)] = (mq[k].size() == DEPTH);

            if (model_ok) begin
                chk("issue_valid", 64'(bus.issue_valid), 64'(ev));
                if (ev) begin
                    chk("issue_wave", 64'(bus.issue_wave), 64'(win));
                    chk("issue_inst", bus.issue_inst, mq[win][0]);
                end
                chk("ifetch_ready", 64'(bus.ifetch_ready), 64'(er));
                chk("ib_full", 64'(bus.ib_full), 64'(ef));
            end
            if (rst_n && bus.issue_valid && bus.issue_ready) hs_log.push_back(int'(bus.issue_wave));

            if (!rst_n) begin
                for (int k = 0; k < NW; k++) begin
                    mq[k].delete();
                    infl[k] = 0;
                end
                rr = 0; lk = 0; lkw = 0;
                model_ok = 1;
            end else if (model_ok) begin
                dold = infl[dw];
                if (ev && bus.issue_ready) begin
                    void'(mq[win].pop_front());
                    infl[win]++;
                    rr = (win + 1) % NW;
                    lk = 0;
                end else if (fhit) begin
                    lk = 0;
                end else if (ev) begin
                    lk  = 1;
                    lkw = win;
                end
                if (bus.done_valid && dold > 0) infl[dw]--;
                if (bus.flush_valid) mq[fw].delete();
                if (bus.ifetch_valid && er) mq[ifw].push_back(bus.ifetch_inst);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push(input int w, input int k);
        bus.ifetch_valid = 1'b1;
        bus.ifetch_wave  = 2'(w);
        bus.ifetch_inst  = mk(w, k);
        tick();
        bus.ifetch_valid = 1'b0;
    endtask

    initial begin : stim
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_n             = 1'b0;
        bus.ifetch_valid  = 1'b1;
        bus.ifetch_wave   = '0;
        bus.ifetch_inst   = mk(0, 7);
        bus.issue_ready   = 1'b0;
        bus.done_valid    = 1'b0;
        bus.done_wave     = '0;
        bus.wave_enable   = 4'hF;
        bus.flush_valid   = 1'b0;
        bus.flush_wave    = '0;

        // Reset with a fetch held valid; first post-reset push is visible one cycle later.
        repeat (3) tick();
        settle();
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_ib_full", 64'(bus.ib_full), 64'd0);
        chk("rst_ifetch_ready", 64'(bus.ifetch_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        bus.ifetch_valid = 1'b0;
        settle();
        chk("t1_valid", 64'(bus.issue_valid), 64'd1);
        chk("t1_wave", 64'(bus.issue_wave), 64'd0);
        chk("t1_inst", bus.issue_inst, mk(0, 7));
        tick();
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        bus.done_valid  = 1'b1;
        bus.done_wave   = 2'd0;
        tick();
        bus.done_valid  = 1'b0;

        // Round-robin over four loaded waves.
        for (int w = 0; w < NW; w++) for (int k = 0; k < 2; k++) push(w, k);
        hs_log.delete();
        for (int i = 0; i < 9; i++) begin
            bus.issue_ready = 1'b1;
            bus.done_valid  = (i > 0);
            bus.done_wave   = 2'((i + 3) % 4);
            tick();
        end
        bus.issue_ready = 1'b0;
        bus.done_valid  = 1'b0;
        chk("t2_count", 64'(hs_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < hs_log.size(); i++) chk("t2_order", 64'(hs_log[i]), 64'(i % 4));

        // Inflight cap on wave 1 and release by one completion.
        for (int k = 0; k < 3; k++) push(1, k);
        hs_log.delete();
        bus.issue_ready = 1'b1;
        repeat (4) tick();
        settle();
        chk("t3_capped", 64'(bus.issue_valid), 64'd0);
        chk("t3_two_issued", 64'(hs_log.size()), 64'd2);
        tick();
        bus.done_valid = 1'b1;
        bus.done_wave  = 2'd1;
        settle();
        chk("t3_done_cycle", 64'(bus.issue_valid), 64'd0);
        tick();
        bus.done_valid = 1'b0;
        settle();
        chk("t3_release_valid", 64'(bus.issue_valid), 64'd1);
        chk("t3_release_inst", bus.issue_inst, mk(1, 2));
        tick();
        bus.issue_ready = 1'b0;
        bus.done_valid  = 1'b1;
        repeat (2) tick();
        bus.done_valid  = 1'b0;
        chk("t3_total", 64'(hs_log.size()), 64'd3);

        // Lock holds wave 2 while it is disabled and wave 0 is eligible.
        push(2, 0);
        push(0, 0);
        bus.wave_enable = 4'b1011;
        hs_log.delete();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_hold_wave", 64'(bus.issue_wave), 64'd2);
            chk("t4_hold_inst", bus.issue_inst, mk(2, 0));
            tick();
        end
        bus.issue_ready = 1'b1;
        repeat (2) tick();
        bus.issue_ready = 1'b0;
        chk("t4_count", 64'(hs_log.size()), 64'd2);
        if (hs_log.size() == 2) begin
            chk("t4_first", 64'(hs_log[0]), 64'd2);
            chk("t4_second", 64'(hs_log[1]), 64'd0);
        end
        bus.wave_enable = 4'hF;
        bus.done_valid  = 1'b1;
        bus.done_wave   = 2'd2;
        tick();
        bus.done_wave   = 2'd0;
        tick();
        bus.done_valid  = 1'b0;

        // Fill wave 3, refuse a fifth fetch, then flush it while locked.
        for (int k = 0; k < 4; k++) push(3, k);
        bus.ifetch_valid = 1'b1;
        bus.ifetch_wave  = 2'd3;
        bus.ifetch_inst  = mk(3, 9);
        settle();
        chk("t5_full", 64'(bus.ib_full), 64'b1000);
        chk("t5_refuse", 64'(bus.ifetch_ready), 64'd0);
        chk("t5_locked_valid", 64'(bus.issue_valid), 64'd1);
        tick();
        bus.ifetch_valid = 1'b0;
        bus.flush_valid  = 1'b1;
        bus.flush_wave   = 2'd3;
        settle();
        chk("t5_flush_drop", 64'(bus.issue_valid), 64'd0);
        tick();
        bus.flush_valid = 1'b0;
        settle();
        chk("t5_after_valid", 64'(bus.issue_valid), 64'd0);
        chk("t5_after_full", 64'(bus.ib_full), 64'd0);
        tick();

        // Simultaneous issue and completion on wave 0 leaves inflight unchanged.
        push(0, 0);
        push(0, 1);
        hs_log.delete();
        bus.issue_ready = 1'b1;
        tick();
        bus.done_valid = 1'b1;
        bus.done_wave  = 2'd0;
        tick();
        bus.done_valid = 1'b0;
        push(0, 2);
        push(0, 3);
        repeat (2) tick();
        settle();
        chk("t6_cap", 64'(bus.issue_valid), 64'd0);
        chk("t6_issued", 64'(hs_log.size()), 64'd3);
        tick();
        bus.done_valid = 1'b1;
        bus.done_wave  = 2'd2;
        tick();
        bus.done_wave  = 2'd0;
        repeat (2) tick();
        bus.done_valid = 1'b0;
        hs_log.delete();
        for (int k = 0; k < 3; k++) push(2, k);
        repeat (4) tick();
        cnt = 0;
        foreach (hs_log[i]) if (hs_log[i] == 2) cnt++;
        chk("t6_idle_done_ignored", 64'(cnt), 64'd2);
        settle();
        chk("t6_end_valid", 64'(bus.issue_valid), 64'd0);
        bus.issue_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
